// File: rtl/memory_access_unit_pkg.sv
// Shared types and constants for the data-memory access stage.
package memory_access_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } state_e;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

endpackage

// File: rtl/memory_access_unit_load_store_align.sv
// Combinational lane steering for stores, extension for loads, and legality checks.
module memory_access_unit_load_store_align
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            byte_en_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  misaligned_o,
  output logic                  illegal_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    byte_en_o = 4'b1111;
    wdata_o   = store_data_i;
    if (is_store_i) begin
      case (funct3_i)
        Funct3Sb: begin
          byte_en_o = 4'b0001 << addr_lo_i;
          wdata_o   = {4{store_data_i[7:0]}};
        end
        Funct3Sh: begin
          byte_en_o = 4'b0011 << {addr_lo_i[1], 1'b0};
          wdata_o   = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    lane_h = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      Funct3Lb:  load_data_o = {{24{lane_b[7]}}, lane_b};
      Funct3Lh:  load_data_o = {{16{lane_h[15]}}, lane_h};
      Funct3Lbu: load_data_o = {24'd0, lane_b};
      Funct3Lhu: load_data_o = {16'd0, lane_h};
      default:   load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    illegal_o = 1'b0;
    if (is_store_i) begin
      illegal_o = funct3_i > Funct3Sw;
    end else if (is_load_i) begin
      illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    end
    // funct3[1:0] encodes access size for every legal load/store
    misaligned_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: issues load/store requests over valid/ready and returns writeback results.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [2:0]              funct3,
  input  logic [DATA_WIDTH-1:0]   ALU_result,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [4:0]              rd,
  output logic                    dmem_req_valid,
  input  logic                    dmem_req_ready,
  output logic                    dmem_req_write,
  output logic [ADDRESS_BITS-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
  output logic [3:0]              dmem_req_byte_en,
  input  logic                    dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   dmem_resp_rdata,
  output logic                    wb_valid,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic [4:0]              wb_rd,
  output logic                    fault,
  output logic                    stall,
  input  logic                    report
);

  state_e                  state_q;
  logic                    write_q;
  logic [2:0]              funct3_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              byte_en_q;
  logic [4:0]              rd_q;
  logic                    wb_valid_q;
  logic [DATA_WIDTH-1:0]   wb_data_q;
  logic [4:0]              wb_rd_q;
  logic                    fault_q;

  logic [2:0]            al_funct3;
  logic [1:0]            al_addr_lo;
  logic [3:0]            al_byte_en;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_load_data;
  logic                  al_misaligned;
  logic                  al_illegal;

  // While waiting, the aligner extracts the response using the latched access.
  assign al_funct3  = (state_q == StWait) ? funct3_q : funct3;
  assign al_addr_lo = (state_q == StWait) ? addr_q[1:0] : ALU_result[1:0];

  memory_access_unit_load_store_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .is_load_i    (mem_read),
    .is_store_i   (mem_write),
    .funct3_i     (al_funct3),
    .addr_lo_i    (al_addr_lo),
    .store_data_i (store_data),
    .rdata_i      (dmem_resp_rdata),
    .byte_en_o    (al_byte_en),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load_data),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      byte_en_q  <= 4'd0;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= 5'd0;
      fault_q    <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ex_valid) begin
            if (!mem_read && !mem_write) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= ALU_result;
              wb_rd_q    <= rd;
            end else if ((mem_read && mem_write) || al_illegal || al_misaligned) begin
              fault_q <= 1'b1;
            end else begin
              write_q   <= mem_write;
              funct3_q  <= funct3;
              addr_q    <= ALU_result[ADDRESS_BITS-1:0];
              wdata_q   <= al_wdata;
              byte_en_q <= al_byte_en;
              rd_q      <= rd;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          if (dmem_req_ready) begin
            state_q <= write_q ? StIdle : StWait;
          end
        end
        StWait: begin
          if (dmem_resp_valid) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= al_load_data;
            wb_rd_q    <= rd_q;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ex_ready         = (state_q == StIdle);
  assign stall            = !ex_ready;
  assign dmem_req_valid   = (state_q == StReq);
  assign dmem_req_write   = write_q;
  assign dmem_req_addr    = {addr_q[ADDRESS_BITS-1:2], 2'b00};
  assign dmem_req_wdata   = wdata_q;
  assign dmem_req_byte_en = byte_en_q;
  assign wb_valid         = wb_valid_q;
  assign wb_data          = wb_data_q;
  assign wb_rd            = wb_rd_q;
  assign fault            = fault_q;

`ifndef SYNTHESIS
  logic [31:0] cycle_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (report) begin
      $display("core %0d cycle %0d state %0d addr %h byte_en %b wb_data %h fault %b",
               CORE, cycle_q, state_q, dmem_req_addr, dmem_req_byte_en, wb_data, fault);
    end
  end
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed plus randomized checks of memory_access_unit against an arithmetic reference model.
module tb_memory_access_unit;

  localparam int KindAlu = 0, KindFault = 1, KindStore = 2, KindLoad = 3;

  logic        clock, reset;
  logic        ex_valid, ex_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] ALU_result, store_data;
  logic [4:0]  rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_write;
  logic [19:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_byte_en;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        fault, stall, report;

  int checks = 0;
  int errors = 0;

  memory_access_unit #(
    .CORE         (0),
    .DATA_WIDTH   (32),
    .ADDRESS_BITS (20)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .funct3           (funct3),
    .ALU_result       (ALU_result),
    .store_data       (store_data),
    .rd               (rd),
    .dmem_req_valid   (dmem_req_valid),
    .dmem_req_ready   (dmem_req_ready),
    .dmem_req_write   (dmem_req_write),
    .dmem_req_addr    (dmem_req_addr),
    .dmem_req_wdata   (dmem_req_wdata),
    .dmem_req_byte_en (dmem_req_byte_en),
    .dmem_resp_valid  (dmem_resp_valid),
    .dmem_resp_rdata  (dmem_resp_rdata),
    .wb_valid         (wb_valid),
    .wb_data          (wb_data),
    .wb_rd            (wb_rd),
    .fault            (fault),
    .stall            (stall),
    .report           (report)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: classify the access and compute lanes from size/offset arithmetic.
  function automatic void model(input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] rdata, output int kind,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] ld);
    int size, off;
    logic [31:0] v, mask;
    size = 1 << f3[1:0];
    off  = int'(addr % 4);
    if (!mr && !mw) kind = KindAlu;
    else if (mr && mw) kind = KindFault;
    else if (mw && f3 > 3'd2) kind = KindFault;
    else if (mr && (f3 == 3'd3 || f3 >= 3'd6)) kind = KindFault;
    else if ((addr % size) != 0) kind = KindFault;
    else kind = mw ? KindStore : KindLoad;
    be = 4'hF;
    wd = sd;
    if (mw && size < 4) be = 4'(((1 << size) - 1) << off);
    if (mw && size == 1) wd = {24'd0, sd[7:0]} * 32'h0101_0101;
    if (mw && size == 2) wd = {16'd0, sd[15:0]} * 32'h0001_0001;
    v = rdata >> (8 * off);
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
    end
    ld = v;
  endfunction

  task automatic run_op(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] r,
                        input int ready_wait, input int resp_wait, input logic [31:0] rdata);
    int kind;
    logic [3:0] be;
    logic [31:0] wd, ld, exp_addr;
    model(mr, mw, f3, addr, sd, rdata, kind, be, wd, ld);
    exp_addr = addr & 32'h000F_FFFC;
    chk("ready_before_accept", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f3;
    ALU_result = addr; store_data = sd; rd = r;
    tick();
    ex_valid = 1'b0;
    if (kind == KindAlu) begin
      chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("alu_wb_data", wb_data, addr);
      chk("alu_wb_rd", {27'd0, wb_rd}, {27'd0, r});
      chk("alu_no_stall", {31'd0, stall}, 32'd0);
      chk("alu_no_fault", {31'd0, fault}, 32'd0);
    end else if (kind == KindFault) begin
      chk("fault_pulse", {31'd0, fault}, 32'd1);
      chk("fault_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("fault_no_req", {31'd0, dmem_req_valid}, 32'd0);
      tick();
      chk("fault_single", {31'd0, fault}, 32'd0);
      chk("fault_no_req2", {31'd0, dmem_req_valid}, 32'd0);
    end else begin
      chk("req_valid", {31'd0, dmem_req_valid}, 32'd1);
      chk("req_write", {31'd0, dmem_req_write}, {31'd0, mw});
      chk("req_addr", {12'd0, dmem_req_addr}, exp_addr);
      chk("req_byte_en", {28'd0, dmem_req_byte_en}, {28'd0, be});
      if (mw) chk("req_wdata", dmem_req_wdata, wd);
      chk("req_stall", {31'd0, stall}, 32'd1);
      for (int i = 0; i < ready_wait; i++) begin
        ex_valid = (i % 2) == 0; mem_read = 1'b0; mem_write = 1'b0;
        ALU_result = $urandom; rd = 5'($urandom);
        tick();
        chk("hold_valid", {31'd0, dmem_req_valid}, 32'd1);
        chk("hold_addr", {12'd0, dmem_req_addr}, exp_addr);
        chk("hold_byte_en", {28'd0, dmem_req_byte_en}, {28'd0, be});
        chk("hold_no_wb", {31'd0, wb_valid}, 32'd0);
      end
      ex_valid = 1'b0;
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      chk("req_dropped", {31'd0, dmem_req_valid}, 32'd0);
      if (mw) begin
        chk("store_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("store_ready", {31'd0, ex_ready}, 32'd1);
        tick();
        chk("store_no_wb2", {31'd0, wb_valid}, 32'd0);
      end else begin
        for (int i = 0; i < resp_wait; i++) begin
          dmem_resp_rdata = $urandom;
          tick();
          chk("wait_stall", {31'd0, stall}, 32'd1);
          chk("wait_no_wb", {31'd0, wb_valid}, 32'd0);
        end
        chk("resp_cycle_stall", {31'd0, stall}, 32'd1);
        dmem_resp_valid = 1'b1; dmem_resp_rdata = rdata;
        tick();
        dmem_resp_valid = 1'b0;
        chk("load_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("load_wb_data", wb_data, ld);
        chk("load_wb_rd", {27'd0, wb_rd}, {27'd0, r});
        chk("load_no_fault", {31'd0, fault}, 32'd0);
        chk("load_ready", {31'd0, ex_ready}, 32'd1);
        tick();
        chk("load_wb_single", {31'd0, wb_valid}, 32'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    ALU_result = 32'd0; store_data = 32'd0; rd = 5'd0; dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0; dmem_resp_rdata = 32'd0; report = 1'b0;
    #2;
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_addr", {12'd0, dmem_req_addr}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_op(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'd0, 5'd5, 0, 0, 32'd0);
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0, 0, 0, 32'd0);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'd0, 5'd7, 0, 0, 32'h0080_0000);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'd0, 5'd8, 0, 0, 32'h0080_0000);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 5'd9, 3, 1, 32'hDEAD_BEEF);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 5'd10, 0, 0, 32'd0);
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h1234, 5'd0, 0, 0, 32'd0);
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'd0, 5'd3, 0, 0, 32'd0);
    run_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 5'd3, 0, 0, 32'd0);
    run_op(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'd0, 5'd3, 0, 0, 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] sel;
      sel = 2'($urandom);
      run_op(sel != 2'd0 && sel != 2'd2, sel == 2'd2 || ($urandom_range(0, 15) == 0),
             3'($urandom), $urandom, $urandom, 5'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    // Abort a load mid-wait; a response arriving after release must be ignored.
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    ALU_result = 32'h0000_0400; rd = 5'd12;
    tick();
    ex_valid = 1'b0; dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("midrst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("midrst_addr", {12'd0, dmem_req_addr}, 32'd0);
    chk("midrst_byte_en", {28'd0, dmem_req_byte_en}, 32'd0);
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h5555_AAAA;
    tick();
    dmem_resp_valid = 1'b0;
    chk("late_resp_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("late_resp_idle", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("late_resp_no_wb2", {31'd0, wb_valid}, 32'd0);
    run_op(1'b0, 1'b0, 3'd0, 32'hCAFE_F00D, 32'd0, 5'd31, 0, 0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
